// File: rtl/fetch_unit_if.sv
// Bundle of fetch-stage signals between the fetch unit, the instruction
// memory, the hazard/branch logic and the decode stage.
interface fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int INST_W = 16
);
  logic [ADDR_W-1:0] PC_addr;
  logic [INST_W-1:0] INST_in;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;
  logic [INST_W-1:0] ifid_inst;
  logic [ADDR_W-1:0] ifid_pc;
  logic              ifid_valid;
  logic              halted;
  logic [15:0]       inst_count;

  // Fetch unit side: owns the PC and the IF/ID register.
  modport master (
    output PC_addr, ifid_inst, ifid_pc, ifid_valid, halted, inst_count,
    input  INST_in, stall, redirect, redirect_target
  );

  // Surrounding pipeline / memory side.
  modport slave (
    input  PC_addr, ifid_inst, ifid_pc, ifid_valid, halted, inst_count,
    output INST_in, stall, redirect, redirect_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, IF/ID register, stall, branch
// redirect with flush, and a terminal HALT state left only through reset.
module fetch_unit #(
  parameter int                 ADDR_W    = 16,
  parameter int                 INST_W    = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC  = 16'h0000,
  parameter int                 PC_STEP   = 2,
  parameter logic [INST_W-1:0]  HALT_INST = 16'hFFFF,
  parameter logic [INST_W-1:0]  NOP_INST  = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t            state_reg,      state_next;
  logic [ADDR_W-1:0] pc_reg,         pc_next;
  logic [INST_W-1:0] ifid_inst_reg,  ifid_inst_next;
  logic [ADDR_W-1:0] ifid_pc_reg,    ifid_pc_next;
  logic              ifid_valid_reg, ifid_valid_next;
  logic [15:0]       inst_count_reg, inst_count_next;

  logic [ADDR_W-1:0] aligned_target;
  logic [15:0]       count_inc;

  // Branch targets are halfword aligned; bit 0 is dropped.
  assign aligned_target = bus.redirect_target & ~ADDR_W'(1);
  assign count_inc      = (inst_count_reg == 16'hFFFF) ? inst_count_reg
                                                       : inst_count_reg + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= RUN;
      pc_reg         <= RESET_PC;
      ifid_inst_reg  <= NOP_INST;
      ifid_pc_reg    <= '0;
      ifid_valid_reg <= 1'b0;
      inst_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      ifid_inst_reg  <= ifid_inst_next;
      ifid_pc_reg    <= ifid_pc_next;
      ifid_valid_reg <= ifid_valid_next;
      inst_count_reg <= inst_count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    ifid_inst_next  = ifid_inst_reg;
    ifid_pc_next    = ifid_pc_reg;
    ifid_valid_next = ifid_valid_reg;
    inst_count_next = inst_count_reg;

    case (state_reg)
      RUN: begin
        if (bus.redirect) begin
          // Redirect wins over stall and discards whatever is being fetched.
          pc_next         = aligned_target;
          ifid_inst_next  = NOP_INST;
          ifid_pc_next    = '0;
          ifid_valid_next = 1'b0;
        end else if (!bus.stall) begin
          ifid_inst_next  = bus.INST_in;
          ifid_pc_next    = pc_reg;
          ifid_valid_next = 1'b1;
          inst_count_next = count_inc;
          if (bus.INST_in == HALT_INST) begin
            state_next = HALTED;
          end else begin
            pc_next = pc_reg + ADDR_W'(PC_STEP);
          end
        end
      end

      HALTED: begin
        ifid_inst_next  = NOP_INST;
        ifid_pc_next    = '0;
        ifid_valid_next = 1'b0;
      end

      default: begin
        state_next = RUN;
      end
    endcase
  end

  assign bus.PC_addr    = pc_reg;
  assign bus.ifid_inst  = ifid_inst_reg;
  assign bus.ifid_pc    = ifid_pc_reg;
  assign bus.ifid_valid = ifid_valid_reg;
  assign bus.halted     = (state_reg == HALTED);
  assign bus.inst_count = inst_count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized checks of fetch_unit against a simple
// instruction-level model of fetch, stall, redirect and halt.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(16), .INST_W(16)) bus ();

  fetch_unit #(
    .ADDR_W(16), .INST_W(16), .RESET_PC(16'h0000), .PC_STEP(2),
    .HALT_INST(16'hFFFF), .NOP_INST(16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Halfword-addressed instruction memory, combinational read.
  logic [15:0] mem [0:32767];
  assign bus.INST_in = mem[bus.PC_addr[15:1]];

  logic [15:0] m_pc, m_inst, m_ifpc, m_count;
  logic        m_valid, m_halted;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".PC_addr"},    32'(bus.PC_addr),    32'(m_pc));
    chk({tag, ".ifid_inst"},  32'(bus.ifid_inst),  32'(m_inst));
    chk({tag, ".ifid_pc"},    32'(bus.ifid_pc),    32'(m_ifpc));
    chk({tag, ".ifid_valid"}, 32'(bus.ifid_valid), 32'(m_valid));
    chk({tag, ".halted"},     32'(bus.halted),     32'(m_halted));
    chk({tag, ".inst_count"}, 32'(bus.inst_count), 32'(m_count));
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_inst = 16'h0000; m_ifpc = 16'h0000;
    m_valid = 1'b0; m_halted = 1'b0; m_count = 16'h0000;
  endtask

  // One clock edge: apply inputs, predict, then compare just after the edge.
  task automatic step(input string tag, input logic s, input logic r, input logic [15:0] t);
    logic [15:0] word;
    bus.stall = s;
    bus.redirect = r;
    bus.redirect_target = t;
    word = mem[m_pc[15:1]];
    if (m_halted) begin
      m_inst = 16'h0000; m_valid = 1'b0; m_ifpc = 16'h0000;
    end else if (r) begin
      m_pc = {t[15:1], 1'b0};
      m_inst = 16'h0000; m_valid = 1'b0; m_ifpc = 16'h0000;
    end else if (!s) begin
      m_inst = word; m_ifpc = m_pc; m_valid = 1'b1;
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      if (word == 16'hFFFF) m_halted = 1'b1;
      else m_pc = m_pc + 16'd2;
    end
    @(posedge clk);
    #1;
    $display("%s stall=%0b redir=%0b tgt=%h -> pc=%h ifid=%h@%h v=%0b h=%0b cnt=%0d",
             tag, s, r, t, bus.PC_addr, bus.ifid_inst, bus.ifid_pc,
             bus.ifid_valid, bus.halted, bus.inst_count);
    check_all(tag);
  endtask

  // Reset asserted between clock edges; outputs must clear before any edge.
  task automatic async_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    $display("%s async reset -> pc=%h v=%0b h=%0b cnt=%0d",
             tag, bus.PC_addr, bus.ifid_valid, bus.halted, bus.inst_count);
    check_all(tag);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[0]       = 16'h1111;
    mem[1]       = 16'h2222;
    mem[2]       = 16'h3333;
    mem[3]       = 16'h4444;
    mem[16'h20]  = 16'hFFFF;
    mem[16'h08]  = 16'h5555;
    mem[15'h7FFF] = 16'hABCD;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = 16'h0000;
    model_reset();

    rst = 1'b1;
    #6;
    check_all("reset");
    #5;
    rst = 1'b0;

    step("seq0", 1'b0, 1'b0, 16'h0000);
    step("seq1", 1'b0, 1'b0, 16'h0000);
    step("stall0", 1'b1, 1'b0, 16'h0000);
    step("stall1", 1'b1, 1'b0, 16'h0000);
    step("seq2", 1'b0, 1'b0, 16'h0000);
    step("redir_stall", 1'b1, 1'b1, 16'h0041);
    step("halt", 1'b0, 1'b0, 16'h0000);
    step("halted0", 1'b0, 1'b0, 16'h0000);
    step("halted_redir", 1'b0, 1'b1, 16'h0010);
    step("halted_stall", 1'b1, 1'b0, 16'h0000);
    step("halted3", 1'b0, 1'b1, 16'h1234);
    step("halted4", 1'b0, 1'b0, 16'h0000);
    async_reset("rst_in_halt");

    step("after_rst", 1'b0, 1'b0, 16'h0000);
    step("to_halt_word", 1'b0, 1'b1, 16'h0040);
    step("redir_vs_halt", 1'b0, 1'b1, 16'h0010);
    step("post_redir", 1'b0, 1'b0, 16'h0000);
    step("to_top", 1'b0, 1'b1, 16'hFFFE);
    step("wrap", 1'b0, 1'b0, 16'h0000);
    step("after_wrap", 1'b0, 1'b0, 16'h0000);

    // Random program with occasional HALT words and random control.
    for (int i = 0; i < 32768; i++)
      mem[i] = ($urandom_range(0, 63) == 0) ? 16'hFFFF : 16'($urandom);
    for (int n = 0; n < 400; n++) begin
      if ((m_halted && $urandom_range(0, 5) == 0) || $urandom_range(0, 79) == 0)
        async_reset("rnd_rst");
      else
        step("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
             16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory. Owns the program counter, which it drives onto the memory's `PC_addr` input.
- Registers the returned `INST_out` word into the IF/ID pipeline register.
- Handles stall, branch redirect/flush, and a terminal HALT instruction.
- Feeds the decode stage of the 5-stage pipeline.

Parameters:
- ADDR_W, 16, PC / address width
- INST_W, 16, instruction width
- RESET_PC, 16'h0000, PC value loaded on reset
- PC_STEP, 2, byte increment per sequential fetch
- HALT_INST, 16'hFFFF, encoding that stops fetch
- NOP_INST, 16'h0000, bubble encoding inserted on flush/halt

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- PC_addr  output  ADDR_W  fetch address to instruction memory
- INST_in  input  INST_W  instruction memory read data; combinational on PC_addr, valid in the same cycle
- stall  input  1  hazard unit: hold PC and IF/ID
- redirect  input  1  taken branch/jump resolved in ID
- redirect_target  input  ADDR_W  new fetch address
- ifid_inst  output  INST_W  registered instruction to decode
- ifid_pc  output  ADDR_W  address of ifid_inst
- ifid_valid  output  1  ifid_inst is a real instruction
- halted  output  1  fetch has stopped on HALT_INST
- inst_count  output  16  instructions delivered to IF/ID, saturating

Behaviour:
- Reset (asynchronous, any time, including mid-stall or while HALTED):
  - PC_addr=RESET_PC, ifid_inst=NOP_INST, ifid_pc=0, ifid_valid=0, halted=0, inst_count=0, state=RUN.
  - First rising edge after rst deasserts performs a normal fetch of RESET_PC.
- States: RUN, HALTED. HALTED is exited only by rst.
- Per-edge priority in RUN: redirect > stall > halt detect > normal.
- Normal (RUN, !stall, !redirect, INST_in != HALT_INST):
  - PC <= PC + PC_STEP, modulo 2^ADDR_W (0xFFFE -> 0x0000).
  - ifid_inst <= INST_in, ifid_pc <= PC, ifid_valid <= 1, inst_count += 1.
- Redirect (RUN, regardless of stall):
  - PC <= {redirect_target[ADDR_W-1:1], 1'b0}, so bit 0 is forced low.
  - IF/ID flushed: ifid_inst <= NOP_INST, ifid_valid <= 0, ifid_pc <= 0.
  - inst_count unchanged.
  - A HALT_INST being fetched in the same cycle is discarded and the state stays RUN.
- Stall (RUN, !redirect):
  - PC, IF/ID, and inst_count all hold.
  - HALT_INST on INST_in is not acted on while stalled.
- Halt detect (RUN, !stall, !redirect, INST_in == HALT_INST):
  - ifid_inst <= HALT_INST, ifid_pc <= PC, ifid_valid <= 1, inst_count += 1.
  - PC holds; state <= HALTED; halted <= 1 on the same edge.
- HALTED:
  - PC holds; redirect and stall are ignored.
  - Each edge loads a bubble: ifid_inst <= NOP_INST, ifid_valid <= 0, ifid_pc <= 0.
- inst_count saturates at 16'hFFFF.
- Latency: the instruction at address A appears on ifid_inst one edge after PC_addr == A, provided that edge is not stalled or redirected.
- All outputs change only on clk rising edge or rst; there are no combinational input-to-output paths.

Test Plan:
- Reset/sequential:
  - Stimulus: rst high 11 ns, then release; memory holds words 0x1111, 0x2222, 0x3333 at addresses 0, 2, 4.
  - Required: PC_addr steps 0000 -> 0002 -> 0004 -> 0006; ifid_inst 1111/2222/3333 with ifid_pc 0000/0002/0004; ifid_valid=1 from the first post-reset edge; inst_count=3.
- Stall:
  - Stimulus: stall high for 2 cycles while PC_addr=0004.
  - Required: PC_addr stays 0004; ifid_inst stays 2222; inst_count frozen. After release, 3333 is loaded and PC_addr=0006.
- Redirect:
  - Stimulus: at PC_addr=0006, assert redirect with target 0x0041, with stall also high.
  - Required: next PC_addr=0040; ifid_valid=0; ifid_inst=0000; inst_count unchanged.
- Halt:
  - Stimulus: word at 0x0040 is FFFF.
  - Required: ifid_inst=FFFF, ifid_valid=1, halted=1. PC_addr stays 0040 for 5 further cycles, including while redirect is asserted. Subsequent ifid_valid=0.
- Redirect vs halt:
  - Stimulus: FFFF on INST_in in the same cycle as redirect to 0x0010.
  - Required: halted stays 0; PC_addr=0010.
- Async reset mid-operation and wrap:
  - Stimulus: rst asserted between clock edges while HALTED.
  - Required: all outputs reach reset values immediately, without waiting for a clock edge.
  - Stimulus: separately, redirect to FFFE with no stall.
  - Required: the following PC_addr is 0000.
